jk_counter_ctrl: RTL
====================

# jk_counter_ctrl

Sequencer for a bank of `WIDTH` JK flip-flops wired as a counter register, sharing `CLK` and `RST_n` with the bank. It accepts clear, load and count-up/count-down commands over a valid/ready handshake. Each cycle it drives the bank's J/K inputs from the bank's Q feedback, producing a mod-`MOD` counter. It reports completion, wrap and error events to the surrounding control logic.

## Interface
- `WIDTH`, 4: number of JK flip-flops in the bank.
- `MOD`, 10: counter modulus; legal range 2..2^WIDTH.
- `CLK` in 1: single clock, rising-edge active; the bank samples J/K on the same edge.
- `RST_n` in 1: asynchronous, active-low reset; the same net resets the bank (bank Q = 0).
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller can accept a command (high only in IDLE).
- `cmd_op` in 2: 00 clear, 01 load, 10 count up, 11 count down.
- `cmd_data` in WIDTH: load value (load only).
- `cmd_steps` in 8: number of count steps (count ops only).
- `q_fb` in WIDTH: Q outputs of the bank.
- `j` out WIDTH, `k` out WIDTH: J/K drive to the bank; combinational from state, latched op and `q_fb`.
- `busy` out 1: command in progress (state is not IDLE).
- `done` out 1: one-cycle pulse, command finished.
- `err` out 1: one-cycle pulse coincident with `done`, load value rejected.
- `wrap` out 1: one-cycle pulse, the bank wrapped on the previous edge.

## Operation
- **States:**
  - IDLE: `j=k=0`, which holds the bank.
  - APPLY: clear or load, one cycle.
  - RUN: counting.
  - FIN: reports completion.
- **Accept:** a handshake occurs when `cmd_valid & cmd_ready` is true at a rising edge. `cmd_op`, `cmd_data` and `cmd_steps` are latched internally. Inputs are ignored while not in IDLE.
- **Clear / load, IDLE->APPLY:**
  - Target t = 0 for clear, t = `cmd_data` for load.
  - Drive uses set/reset encoding: `j = t`, `k = ~t`. This is independent of `q_fb`.
  - Then go to FIN.
- **Illegal load:** a load with `cmd_data >= MOD` goes IDLE->FIN directly. The bank is not touched, and `err` pulses with `done`.
- **Count, IDLE->RUN:** the remaining-step counter is loaded with `cmd_steps`.
  - If `cmd_steps == 0`, go IDLE->FIN directly with no bank change.
  - Each RUN cycle computes target t = next(`q_fb`).
  - Drive uses toggle encoding: `j = k = q_fb ^ t`. Differing bits toggle; equal bits hold.
  - Decrement remaining each cycle; on the cycle remaining == 1, go to FIN.
- **next() for count up:** `q_fb >= MOD-1` gives 0; otherwise `q_fb + 1`.
- **next() for count down:** `q_fb == 0` or `q_fb >= MOD` gives MOD-1; otherwise `q_fb - 1`.
- **Wrap:** a RUN cycle whose transition is up to 0 or down to MOD-1 sets `wrap`, registered, in the following cycle. Transitions out of an out-of-range `q_fb` also count as a wrap.
- **FIN:** `done=1` (and `err` if flagged); `j=k=0`; next state IDLE.
- **Arithmetic:** next() is computed at WIDTH+1 bits so that MOD = 2^WIDTH is legal.

## Timing
- **Reset (async, while `RST_n=0`):** state = IDLE, so `cmd_ready=1`. `busy=0`, `done=0`, `err=0`, `wrap=0`, `j=k=0`, internal registers 0.
- **Reset mid-command:** the command is aborted immediately and the bank resets to 0. No `done` pulse is produced.
- **Clear / load:** accept at edge E0; APPLY during E0..E1; bank holds t after E1. `done` is high E1..E2, and `cmd_ready` is high again after E2.
- **Count of N steps:** accept at E0; the bank updates at E1..EN; `done` is high EN..EN+1.
- **Back-to-back commands:** the earliest next accept is the edge after the `done` cycle. Minimum spacing is 3 cycles for clear/load and N+2 cycles for a count.
- **Zero-step count or illegal load:** `done` is high E0..E1; the bank is unchanged.
- **`wrap`:** high in the cycle after the edge at which the bank wrapped. It may coincide with `done` when the last step wraps.
- **`j`/`k`:** must settle within the cycle from `q_fb`. `q_fb` comes from bank registers, so there is no combinational loop.

## Test plan
- **Reset value check:** hold `RST_n=0` for 3 cycles, release -> `cmd_ready=1`, `busy=0`, `j=k=0`, `q_fb=0`; idle 5 cycles -> bank stays 0.
- **Load, then clear:** load 7 -> bank = 7 one edge after accept, `done` the next cycle, `err=0`; then clear -> bank = 0.
- **Illegal load:** load 12 with MOD=10 -> `done=1` and `err=1` one cycle after accept; bank unchanged.
- **Count up with wrap:** load 8, then count up with steps=3 -> bank sequence 9, 0, 1; `wrap` pulses once, after the 9->0 edge; `done` after the third edge.
- **Count down with wrap:** load 1, then count down with steps=2 -> bank sequence 0, 9; `wrap` coincides with `done`. Also issue a count with steps=0 -> immediate `done`, no change.
- **Reset mid-count and ignored inputs:** count up with steps=200, assert `RST_n=0` at step 50 -> all outputs reset, no `done`. Also toggle `cmd_valid` while busy -> no effect.

Source files
------------

// File: rtl/jk_counter_ctrl_if.sv
// Command/status bus between the surrounding control logic and the JK counter sequencer.
interface jk_counter_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [7:0]       cmd_steps;
  logic             busy;
  logic             done;
  logic             err;
  logic             wrap;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_steps,
    input  cmd_ready, busy, done, err, wrap
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_steps,
    output cmd_ready, busy, done, err, wrap
  );
endinterface

// File: rtl/jk_counter_ctrl.sv
// Sequencer driving a bank of JK flip-flops as a mod-MOD counter with clear/load/count
// commands accepted over a valid/ready handshake.
module jk_counter_ctrl #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             CLK,
  input  logic             RST_n,
  jk_counter_ctrl_if.slave cmd,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    RUN   = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [1:0]     OP_CLEAR = 2'b00;
  localparam logic [1:0]     OP_LOAD  = 2'b01;
  localparam logic [1:0]     OP_UP    = 2'b10;
  // One extra bit so MOD == 2^WIDTH stays representable.
  localparam logic [WIDTH:0] MOD_W    = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0] MOD_M1   = (WIDTH+1)'(MOD - 1);
  localparam logic [WIDTH:0] ONE_W    = (WIDTH+1)'(1);

  state_t           state_r, state_s;
  logic [1:0]       op_r, op_s;
  logic [WIDTH-1:0] data_r, data_s;
  logic [7:0]       remain_r, remain_s;
  logic             err_r, err_s;
  logic             wrap_r, wrap_s;
  logic [WIDTH:0]   nxt_s;
  logic [WIDTH-1:0] tgt_s;

  // Out-of-range feedback is folded back into 0..MOD-1 in both directions.
  function automatic logic [WIDTH:0] next_val(input logic up, input logic [WIDTH:0] q);
    logic [WIDTH:0] r;
    if (up) begin
      if (q >= MOD_M1) r = {(WIDTH+1){1'b0}};
      else             r = q + ONE_W;
    end else begin
      if ((q == {(WIDTH+1){1'b0}}) || (q >= MOD_W)) r = MOD_M1;
      else                                          r = q - ONE_W;
    end
    return r;
  endfunction

  // Next-state, latched-command and J/K drive decode.
  always_comb begin
    state_s  = state_r;
    op_s     = op_r;
    data_s   = data_r;
    remain_s = remain_r;
    err_s    = 1'b0;
    wrap_s   = 1'b0;
    j        = {WIDTH{1'b0}};
    k        = {WIDTH{1'b0}};
    nxt_s    = next_val(op_r == OP_UP, {1'b0, q_fb});
    tgt_s    = (op_r == OP_LOAD) ? data_r : {WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        if (cmd.cmd_valid) begin
          op_s     = cmd.cmd_op;
          data_s   = cmd.cmd_data;
          remain_s = cmd.cmd_steps;
          case (cmd.cmd_op)
            OP_CLEAR: state_s = APPLY;
            OP_LOAD: begin
              if ({1'b0, cmd.cmd_data} >= MOD_W) begin
                state_s = FIN;
                err_s   = 1'b1;
              end else begin
                state_s = APPLY;
              end
            end
            default: begin
              if (cmd.cmd_steps == 8'd0) state_s = FIN;
              else                       state_s = RUN;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      APPLY: begin
        j       = tgt_s;
        k       = ~tgt_s;
        state_s = FIN;
      end
      RUN: begin
        // Toggle encoding: only bits that differ from the target flip.
        j        = q_fb ^ nxt_s[WIDTH-1:0];
        k        = q_fb ^ nxt_s[WIDTH-1:0];
        remain_s = remain_r - 8'd1;
        wrap_s   = (op_r == OP_UP) ? (nxt_s == {(WIDTH+1){1'b0}}) : (nxt_s == MOD_M1);
        if (remain_r == 8'd1) state_s = FIN;
        else                  state_s = RUN;
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State and latched command registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_r  <= IDLE;
      op_r     <= 2'b00;
      data_r   <= {WIDTH{1'b0}};
      remain_r <= 8'd0;
      err_r    <= 1'b0;
      wrap_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      op_r     <= op_s;
      data_r   <= data_s;
      remain_r <= remain_s;
      err_r    <= err_s;
      wrap_r   <= wrap_s;
    end
  end

  assign cmd.cmd_ready = (state_r == IDLE);
  assign cmd.busy      = (state_r != IDLE);
  assign cmd.done      = (state_r == FIN);
  assign cmd.err       = err_r;
  assign cmd.wrap      = wrap_r;

endmodule
